transmissor_serial: RTL and testbench

TRANSMISSOR_SERIAL -- requirements
Module: transmissor_serial

---
 rtl/transmissor_serial.sv | 128 ++++++++++++
 tb/tb_transmissor_serial.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/transmissor_serial.sv
// Serial frame transmitter: start bit, LSB-first payload, optional even parity, stop bit.
// Every output is registered and updated together with the state on the same edge.
module transmissor_serial #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [DATA_BITS-1:0] Data,
   output logic                 X,
   output logic                 Busy,
   output logic                 Done
);

   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
   localparam logic [7:0]    LAST_CNT = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t               state;
   logic [7:0]           cnt;
   logic [IW-1:0]        idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] shreg_next;
   logic                 par;
   logic                 bit_end;

   assign bit_end    = (cnt == LAST_CNT);
   assign shreg_next = shreg >> 1;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         par   <= 1'b0;
         X     <= 1'b1;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               X    <= 1'b1;
               Busy <= 1'b0;
               if (Start) begin
                  shreg <= Data;
                  par   <= ^Data;
                  cnt   <= '0;
                  idx   <= '0;
                  state <= START;
                  X     <= 1'b0;
                  Busy  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= DATA;
                  X     <= shreg[0];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (idx == LAST_IDX) begin
                     // X is loaded with the level of the state being entered.
                     if (PARITY_EN != 0) begin
                        state <= PARITY;
                        X     <= par;
                     end else begin
                        state <= STOP;
                        X     <= 1'b1;
                     end
                  end else begin
                     idx   <= idx + 1'b1;
                     shreg <= shreg_next;
                     X     <= shreg_next[0];
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            PARITY: begin
               if (bit_end) begin
                  cnt   <= '0;
                  state <= STOP;
                  X     <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= IDLE;
                  X     <= 1'b1;
                  Busy  <= 1'b0;
                  Done  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               idx   <= '0;
               X     <= 1'b1;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transmissor_serial.sv
// Bench for transmissor_serial: default build plus a 4-bit, 1-clock, no-parity build,
// both compared every cycle against a queue-of-levels frame model.
module tb_transmissor_serial;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       Start;
   logic [7:0] Data;
   logic       X, Busy, Done;
   logic       s_start;
   logic [3:0] s_data;
   logic       s_x, s_busy, s_done;

   int n_cmp = 0;
   int n_err = 0;

   typedef bit bitq_t[$];
   bitq_t q0, q1;
   bit    d0, d1;
   int    run0, run1;

   always #5 Clock = ~Clock;

   transmissor_serial dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .Data(Data),
      .X(X), .Busy(Busy), .Done(Done)
   );

   transmissor_serial #(.DATA_BITS(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_s (
      .Clock(Clock), .Reset(Reset), .Start(s_start), .Data(s_data),
      .X(s_x), .Busy(s_busy), .Done(s_done)
   );

   // Expected line level for each cycle of a whole frame.
   function automatic bitq_t build(int data, int nb, int cpb, int pe);
      bitq_t f;
      bit    lvl;
      bit    p;
      p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= data[i];
      for (int b = 0; b < nb + 2 + pe; b++) begin
         if (b == 0)                      lvl = 1'b0;
         else if (b <= nb)                lvl = data[b-1];
         else if (pe != 0 && b == nb + 1) lvl = p;
         else                             lvl = 1'b1;
         for (int c = 0; c < cpb; c++) f.push_back(lvl);
      end
      return f;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      d0   = 1'b0;
      d1   = 1'b0;
      run0 = 0;
      run1 = 0;
   endtask

   task automatic step();
      @(posedge Clock);
      if (!Reset) begin
         model_reset();
      end else begin
         if (q0.size() != 0) begin
            void'(q0.pop_front());
            d0 = (q0.size() == 0);
         end else begin
            d0 = 1'b0;
            if (Start) q0 = build(int'(Data), 8, 4, 1);
         end
         if (q1.size() != 0) begin
            void'(q1.pop_front());
            d1 = (q1.size() == 0);
         end else begin
            d1 = 1'b0;
            if (s_start) q1 = build(int'(s_data), 4, 1, 0);
         end
      end
      #1;
      check("x",      int'(X),      (q0.size() != 0) ? int'(q0[0]) : 1);
      check("busy",   int'(Busy),   (q0.size() != 0) ? 1 : 0);
      check("done",   int'(Done),   int'(d0));
      check("s_x",    int'(s_x),    (q1.size() != 0) ? int'(q1[0]) : 1);
      check("s_busy", int'(s_busy), (q1.size() != 0) ? 1 : 0);
      check("s_done", int'(s_done), int'(d1));
      if (Busy) run0++;
      else if (run0 != 0) begin
         check("busy_len", run0, 44);
         run0 = 0;
      end
      if (s_busy) run1++;
      else if (run1 != 0) begin
         check("s_busy_len", run1, 6);
         run1 = 0;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check_reset_outputs();
      check("rst_x",      int'(X),      1);
      check("rst_busy",   int'(Busy),   0);
      check("rst_done",   int'(Done),   0);
      check("rst_s_x",    int'(s_x),    1);
      check("rst_s_busy", int'(s_busy), 0);
      check("rst_s_done", int'(s_done), 0);
   endtask

   initial begin
      Reset   = 1'b1;
      Start   = 1'b0;
      Data    = '0;
      s_start = 1'b0;
      s_data  = '0;
      model_reset();
      #2 Reset = 1'b0;
      #1 check_reset_outputs();
      steps(2);
      Reset = 1'b1;
      steps(2);

      // 0xA5 (even parity 0) and 0x07 (parity 1); small build sends 0xC
      Data = 8'hA5; Start = 1'b1; s_data = 4'hC; s_start = 1'b1;
      step();
      Start = 1'b0; s_start = 1'b0;
      steps(50);
      Data = 8'h07; Start = 1'b1; s_start = 1'b1;
      step();
      Start = 1'b0; s_start = 1'b0;
      steps(50);

      // Start held high: back-to-back frames, Data scrambled throughout
      Start = 1'b1; s_start = 1'b1;
      for (int i = 0; i < 140; i++) begin
         step();
         Data   = 8'($urandom);
         s_data = 4'($urandom);
      end
      Start = 1'b0; s_start = 1'b0;
      steps(50);

      // Abort during payload bit 3, checked before any clock edge
      Data = 8'h3C; Start = 1'b1;
      step();
      Start = 1'b0;
      steps(17);
      #3 Reset = 1'b0;
      #1 check_reset_outputs();
      model_reset();
      steps(2);
      Reset = 1'b1;
      steps(3);
      Data = 8'($urandom); Start = 1'b1;
      step();
      Start = 1'b0;
      steps(50);

      // Random traffic with Data changing every cycle
      for (int i = 0; i < 400; i++) begin
         Start   = ($urandom_range(0, 7) == 0);
         s_start = ($urandom_range(0, 3) == 0);
         Data    = 8'($urandom);
         s_data  = 4'($urandom);
         step();
      end
      Start = 1'b0; s_start = 1'b0;
      steps(50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
